// File: rtl/idct_pkg.sv
// Shared constants, state encoding and the VVC DCT-II coefficient lookup
// used by the inverse (and forward) 1-D transform blocks.
package idct_pkg;

  localparam int unsigned LANES  = 32;
  localparam int unsigned LANE_W = 16;
  localparam int unsigned COEF_W = 8;

  localparam logic [1:0] SZ_4  = 2'd0;
  localparam logic [1:0] SZ_8  = 2'd1;
  localparam logic [1:0] SZ_16 = 2'd2;
  localparam logic [1:0] SZ_32 = 2'd3;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Quarter-wave magnitudes of the VVC 64-point DCT-II matrix, indexed by the
  // phase k*(2n+1) in units of pi/128 (0..64); entry 0 doubles as the DC gain.
  localparam logic [7:0] T64_QW [65] = '{
    8'd64, 8'd91, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90, 8'd90,
    8'd89, 8'd88, 8'd88, 8'd87, 8'd87, 8'd86, 8'd85, 8'd84,
    8'd83, 8'd83, 8'd82, 8'd81, 8'd80, 8'd79, 8'd78, 8'd77,
    8'd75, 8'd73, 8'd73, 8'd71, 8'd70, 8'd69, 8'd67, 8'd65,
    8'd64, 8'd62, 8'd61, 8'd59, 8'd57, 8'd56, 8'd54, 8'd52,
    8'd50, 8'd48, 8'd46, 8'd44, 8'd43, 8'd41, 8'd38, 8'd37,
    8'd36, 8'd33, 8'd31, 8'd28, 8'd25, 8'd24, 8'd22, 8'd20,
    8'd18, 8'd15, 8'd13, 8'd11, 8'd9,  8'd7,  8'd4,  8'd2,
    8'd0
  };

  // T64[row][col]: phase taken mod 256, folded onto the first quadrant.
  function automatic coef_t t64(input logic [5:0] row, input logic [4:0] col);
    logic [7:0] a;
    logic [6:0] i;
    logic       neg;
    coef_t      m;
    a = {2'b00, row} * {2'b00, col, 1'b1};
    if (a <= 8'd64) begin
      i   = a[6:0];
      neg = 1'b0;
    end else if (a <= 8'd128) begin
      i   = 7'(8'd128 - a);
      neg = 1'b1;
    end else if (a <= 8'd192) begin
      i   = 7'(a - 8'd128);
      neg = 1'b1;
    end else begin
      i   = 7'(9'd256 - {1'b0, a});
      neg = 1'b0;
    end
    m = coef_t'(T64_QW[i]);
    return neg ? -m : m;
  endfunction

  // T_size[k][n] = T64[k*(64/size)][n], size = 4 << sz; valid for k < size.
  function automatic coef_t tsize(input logic [1:0] sz, input logic [4:0] k,
                                  input logic [4:0] n);
    logic [5:0] r;
    r = {1'b0, k} << (3'd4 - {1'b0, sz});
    return t64(r, n);
  endfunction

endpackage

// File: rtl/dct_coef_col.sv
// Combinational fetch of one DCT-II matrix column: coefficient k of column n
// for the selected size, zero for rows k >= size.
module dct_coef_col
  import idct_pkg::*;
(
  input  logic [1:0]              size_i,
  input  logic [4:0]              n_i,
  output logic [LANES*COEF_W-1:0] col_o
);

  logic [5:0] size;
  assign size = 6'd4 << size_i;

  always_comb begin
    col_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k < 32'(size)) col_o[k*COEF_W +: COEF_W] = tsize(size_i, 5'(k), n_i);
    end
  end

endmodule

// File: rtl/idct2_1d.sv
// Sequential 1-D inverse DCT-II (sizes 4..32): one output sample per cycle
// from 32 parallel multipliers, valid/ready on both sides.
module idct2_1d
  import idct_pkg::*;
#(
  parameter int unsigned SHIFT = 7,
  parameter int unsigned LANES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           N,
  input  logic [LANES*16-1:0]  X,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*16-1:0]  Y
);

  localparam logic signed [31:0] RND = 32'sd1 <<< (SHIFT - 1);

  state_t                    state_q, state_d;
  logic [LANES*16-1:0]       xreg_q, xreg_d;
  logic [LANES*16-1:0]       y_q, y_d;
  logic [1:0]                size_q, size_d;
  logic [4:0]                idx_q, idx_d;
  logic [LANES*COEF_W-1:0]   col;
  logic signed [31:0]        acc;
  logic signed [31:0]        sh;
  logic signed [15:0]        y_clip;
  logic [4:0]                last_idx;

  dct_coef_col u_col (
    .size_i (size_q),
    .n_i    (idx_q),
    .col_o  (col)
  );

  assign last_idx = 5'((6'd4 << size_q) - 6'd1);

  // Column dot product; rows beyond the block size carry zero coefficients.
  always_comb begin
    logic signed [23:0] prod;
    acc = RND;
    for (int unsigned k = 0; k < LANES; k++) begin
      prod = signed'(xreg_q[k*16 +: 16]) * signed'(col[k*COEF_W +: COEF_W]);
      acc  = acc + 32'(prod);
    end
    sh = acc >>> SHIFT;
    if (sh > 32'sd32767)       y_clip = 16'sh7fff;
    else if (sh < -32'sd32768) y_clip = 16'sh8000;
    else                       y_clip = sh[15:0];
  end

  always_comb begin
    state_d = state_q;
    xreg_d  = xreg_q;
    y_d     = y_q;
    size_d  = size_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          xreg_d  = X;
          size_d  = N;
          y_d     = '0;
          idx_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        y_d[idx_q*16 +: 16] = y_clip;
        idx_d               = idx_q + 5'd1;
        if (idx_q == last_idx) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xreg_q  <= '0;
      y_q     <= '0;
      size_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      xreg_q  <= xreg_d;
      y_q     <= y_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;

endmodule

// File: tb/tb_idct2_1d.sv
// Scoreboard bench for idct2_1d: directed cases plus a randomised regression
// with downstream backpressure, checked against an independent reference.
module tb_idct2_1d;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   N;
  logic [511:0] X;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] Y;

  int checks = 0;
  int errors = 0;
  logic [511:0] sb_q[$];
  bit bp_en = 1'b0;

  always #5 clk = ~clk;

  idct2_1d #(.SHIFT(7), .LANES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N         (N),
    .X         (X),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y)
  );

  // Odd-row magnitudes of the 64/32/16/8/4-point VVC matrices.
  int r64[32] = '{91, 90, 90, 90, 88, 87, 86, 84, 83, 81, 79, 77, 73, 71, 69, 65,
                  62, 59, 56, 52, 48, 44, 41, 37, 33, 28, 24, 20, 15, 11, 7, 2};
  int r32[16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
  int r16[8]  = '{90, 87, 80, 70, 57, 43, 25, 9};
  int r8[4]   = '{89, 75, 50, 18};
  int r4[2]   = '{83, 36};

  task automatic check_val(input string tag, input logic [511:0] got,
                           input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mag(input int a);
    int b, p;
    if (a == 0) return 64;
    if (a == 64) return 0;
    b = a; p = 0;
    while (b % 2 == 0) begin b = b / 2; p++; end
    case (p)
      0: return r64[(b-1)/2];
      1: return r32[(b-1)/2];
      2: return r16[(b-1)/2];
      3: return r8[(b-1)/2];
      4: return r4[(b-1)/2];
      default: return 64;
    endcase
  endfunction

  function automatic int bcoef(input int size, input int k, input int n);
    int a;
    a = (k * (64 / size) * (2*n + 1)) % 256;
    if (a <= 64)       return mag(a);
    else if (a <= 128) return -mag(128 - a);
    else if (a < 192)  return -mag(a - 128);
    else               return mag(256 - a);
  endfunction

  function automatic logic [511:0] model(input int nc, input logic [511:0] x);
    int size;
    longint acc, yv;
    logic [511:0] y;
    logic signed [15:0] xl;
    size = 4 << nc;
    y = '0;
    for (int n = 0; n < size; n++) begin
      acc = 64;
      for (int k = 0; k < size; k++) begin
        xl = x[k*16 +: 16];
        acc += longint'(xl) * longint'(bcoef(size, k, n));
      end
      yv = acc >>> 7;
      if (yv > 32767) yv = 32767;
      if (yv < -32768) yv = -32768;
      y[n*16 +: 16] = 16'(yv);
    end
    return y;
  endfunction

  function automatic logic [511:0] fill(input int nlanes, input int v);
    logic [511:0] y;
    y = '0;
    for (int i = 0; i < nlanes; i++) y[i*16 +: 16] = 16'(v);
    return y;
  endfunction

  // Entered and left at posedge+#1; the accept edge is the posedge inside.
  task automatic send(input int nc, input logic [511:0] x);
    int cnt;
    N = 2'(nc); X = x; in_valid = 1'b1; cnt = 0;
    while (!in_ready && cnt < 2000) begin @(posedge clk); #1; cnt++; end
    if (!in_ready) begin
      check_val("send_timeout", 512'(in_ready), 512'd1);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(model(nc, x));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) check_val("sb_empty", 512'(sb_q.size()), 512'd1);
      else                  check_val("sb_y", Y, sb_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [511:0] x, xa, xb, ya;
    int lat, cnt;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; N = '0; X = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_y", Y, '0);
    check_val("rst_out_valid", 512'(out_valid), 512'd0);
    check_val("rst_in_ready", 512'(in_ready), 512'd1);
    rst = 1'b0;

    x = '0; x[15:0] = 16'd64;
    send(0, x);
    wait_valid(lat);
    check_val("lat_4", 512'(lat), 512'd4);
    check_val("dc4_y", Y, fill(4, 32));
    @(posedge clk); #1;

    x = '0; x[15:0] = 16'h7fff;
    send(3, x);
    wait_valid(lat);
    check_val("lat_32", 512'(lat), 512'd32);
    check_val("dc32_y", Y, fill(32, 16384));
    @(posedge clk); #1;

    x = '0; x[15:0] = 16'h7fff; x[31:16] = 16'h7fff;
    send(0, x);
    wait_valid(lat);
    ya = '0;
    ya[15:0] = 16'h7fff; ya[31:16] = 16'h63ff; ya[47:32] = 16'h1c00; ya[63:48] = 16'hed00;
    check_val("clip_floor_y", Y, ya);
    @(posedge clk); #1;

    // Backpressure: DONE holds Y under out_ready=0 and ignores new vectors.
    out_ready = 1'b0;
    xa = '0;
    for (int i = 0; i < 4; i++) xa[i*16 +: 16] = 16'($urandom_range(0, 65534) - 32767);
    send(0, xa);
    wait_valid(lat);
    ya = model(0, xa);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; N = 2'($urandom_range(0, 3));
      X = {16{$urandom()}};
      @(posedge clk); #1;
      check_val("bp_y_hold", Y, ya);
      check_val("bp_in_ready", 512'(in_ready), 512'd0);
      check_val("bp_out_valid", 512'(out_valid), 512'd1);
    end
    xb = '0; xb[15:0] = 16'd64;
    N = 2'd1; X = xb;
    sb_q.push_back(model(1, xb));
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_idle_gap", 512'(in_ready), 512'd1);
    @(posedge clk); #1;
    check_val("bp_next_accept", 512'(in_ready), 512'd0);
    in_valid = 1'b0;
    wait_valid(lat);
    check_val("bp_next_y", Y, fill(8, 32));
    @(posedge clk); #1;

    // Reset while the N=2 job sits at index 5.
    x = {16{$urandom()}};
    send(2, x);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_out_valid", 512'(out_valid), 512'd0);
    check_val("mid_rst_y", Y, '0);
    check_val("mid_rst_in_ready", 512'(in_ready), 512'd1);
    sb_q.delete();
    x = '0; x[15:0] = 16'd64;
    send(1, x);
    wait_valid(lat);
    check_val("post_rst_lat", 512'(lat), 512'd8);
    check_val("post_rst_y", Y, fill(8, 32));
    @(posedge clk); #1;

    bp_en = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      int nc;
      nc = $urandom_range(0, 3);
      x = {16{$urandom()}};
      for (int i = 0; i < 32; i++) x[i*16 +: 16] = 16'($urandom_range(0, 65534) - 32767);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(nc, x);
    end
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 5000) begin @(posedge clk); #1; cnt++; end
    bp_en = 1'b0;
    #1;
    out_ready = 1'b1;
    check_val("sb_drain", 512'(sb_q.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
